// File: rtl/signed_div4_seq_flags_pkg.sv
// Shared types and constants for the sequential signed divider.
// The optional macro DIV4_FAST_PATH_EN is consumed by signed_div4_seq_flags.sv.
package div_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam logic [DEFAULT_WIDTH-1:0] MIN_VAL = {1'b1, {(DEFAULT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    FIX  = 2'd2
  } div_state_t;

  typedef struct packed {
    logic zero;
    logic negative;
    logic carry;
    logic overflow;
  } div_flags_t;

endpackage

// File: rtl/signed_div4_seq_flags_if.sv
// Start/done handshake and result bus between the ALU datapath and the divider.
interface signed_div4_seq_flags_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             zero;
  logic             negative;
  logic             carry;
  logic             overflow;

  modport master (
    output start, a, b,
    input  busy, done, quotient, remainder, zero, negative, carry, overflow
  );

  modport slave (
    input  start, a, b,
    output busy, done, quotient, remainder, zero, negative, carry, overflow
  );
endinterface

// File: rtl/signed_div4_seq_flags_div_step.sv
// One combinational restoring-division step on unsigned magnitudes.
module div_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             bit_in,
  input  logic [WIDTH:0]   divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  // The shifted remainder stays below 2*divisor, so the kept value always fits WIDTH bits.
  always_comb begin
    q_bit    = ({rem, bit_in} >= divisor);
    rem_next = q_bit ? WIDTH'({rem, bit_in} - divisor) : WIDTH'({rem, bit_in});
  end

endmodule

// File: rtl/signed_div4_seq_flags.sv
// Sequential signed divider with ALU flags: IDLE -> DIV (WIDTH steps) -> FIX -> IDLE.
// Define DIV4_FAST_PATH_EN to bypass DIV when a==0 or b==0.
module signed_div4_seq_flags
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic                    clk,
  input logic                    rst,
  signed_div4_seq_flags_if.slave bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH:0]   ONE_X = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MIN_W = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH:0]   dvs_mag;
  logic [WIDTH-1:0] rem_mag;
  logic [WIDTH-1:0] q_mag;
  logic [WIDTH-1:0] a_lat;
  logic             sign_q;
  logic             sign_r;
  logic             div0;
  logic             ovf;

  logic [WIDTH-1:0] quotient_r;
  logic [WIDTH-1:0] remainder_r;
  div_flags_t       flags_r;
  logic             done_r;

  logic [WIDTH-1:0] a_abs;
  logic [WIDTH:0]   b_ext;
  logic [WIDTH:0]   b_abs;
  logic [WIDTH-1:0] rem_next;
  logic             q_bit;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic [WIDTH-1:0] q_out;
  logic [WIDTH-1:0] r_out;

  // |MIN| = 2^(WIDTH-1) is still exact as an unsigned WIDTH-bit dividend magnitude.
  always_comb begin
    a_abs = bus.a[WIDTH-1] ? (~bus.a + ONE_W) : bus.a;
    b_ext = {bus.b[WIDTH-1], bus.b};
    b_abs = b_ext[WIDTH] ? (~b_ext + ONE_X) : b_ext;
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_mag),
    .bit_in   (dvd_mag[cnt]),
    .divisor  (dvs_mag),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  always_comb begin
    q_fix = sign_q ? (~q_mag + ONE_W) : q_mag;
    r_fix = sign_r ? (~rem_mag + ONE_W) : rem_mag;
    q_out = div0 ? '0 : q_fix;
    r_out = div0 ? a_lat : r_fix;
  end

`ifdef DIV4_FAST_PATH_EN
  logic fast;
  assign fast = (bus.a == '0) || (bus.b == '0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      dvd_mag     <= '0;
      dvs_mag     <= '0;
      rem_mag     <= '0;
      q_mag       <= '0;
      a_lat       <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      div0        <= 1'b0;
      ovf         <= 1'b0;
      quotient_r  <= '0;
      remainder_r <= '0;
      flags_r     <= '0;
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            dvd_mag <= a_abs;
            dvs_mag <= b_abs;
            a_lat   <= bus.a;
            sign_q  <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
            sign_r  <= bus.a[WIDTH-1];
            div0    <= (bus.b == '0);
            ovf     <= (bus.a == MIN_W) && (bus.b == '1);
            rem_mag <= '0;
            q_mag   <= '0;
            cnt     <= CW'(WIDTH - 1);
`ifdef DIV4_FAST_PATH_EN
            state   <= fast ? FIX : DIV;
`else
            state   <= DIV;
`endif
          end
        end
        DIV: begin
          rem_mag      <= rem_next;
          q_mag[cnt]   <= q_bit;
          cnt          <= cnt - CW'(1);
          if (cnt == '0) state <= FIX;
        end
        FIX: begin
          quotient_r        <= q_out;
          remainder_r       <= r_out;
          flags_r.zero      <= (q_out == '0);
          flags_r.negative  <= q_out[WIDTH-1];
          flags_r.carry     <= div0;
          flags_r.overflow  <= ovf;
          done_r            <= 1'b1;
          state             <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_r;
  assign bus.quotient  = quotient_r;
  assign bus.remainder = remainder_r;
  assign bus.zero      = flags_r.zero;
  assign bus.negative  = flags_r.negative;
  assign bus.carry     = flags_r.carry;
  assign bus.overflow  = flags_r.overflow;

endmodule

// File: tb/tb_signed_div4_seq_flags.sv
// Self-checking bench for signed_div4_seq_flags: vector table, random ops and handshake corner cases.
module tb_signed_div4_seq_flags;
  import div_pkg::*;

  localparam int W = DEFAULT_WIDTH;

  logic clk = 1'b0;
  logic rst;

  signed_div4_seq_flags_if #(.WIDTH(W)) bus ();
  signed_div4_seq_flags #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    logic         n;
    logic         c;
    logic         v;
  } vec_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t sb[$];
  vec_t tbl[12];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    vec_t e;
    int   sa, sd, qi, ri;
    e.a = a; e.b = b; e.c = 1'b0; e.v = 1'b0;
    if (b == '0) begin
      e.q = '0; e.r = a; e.c = 1'b1;
    end else if (a == MIN_VAL && b == '1) begin
      e.q = MIN_VAL; e.r = '0; e.v = 1'b1;
    end else begin
      sa = int'($signed(a));
      sd = int'($signed(b));
      qi = sa / sd;
      ri = sa % sd;
      e.q = qi[W-1:0];
      e.r = ri[W-1:0];
    end
    e.z = (e.q == '0);
    e.n = e.q[W-1];
    return e;
  endfunction

  function automatic int exp_latency(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef DIV4_FAST_PATH_EN
    return (a == '0 || b == '0) ? 1 : W + 1;
`else
    if (a == b && a == '1) return W + 1;
    return W + 1;
`endif
  endfunction

  task automatic compare_result(input string tag);
    vec_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    check({tag, "_quotient"},  bus.quotient,  e.q);
    check({tag, "_remainder"}, bus.remainder, e.r);
    check({tag, "_zero"},      bus.zero,      e.z);
    check({tag, "_negative"},  bus.negative,  e.n);
    check({tag, "_carry"},     bus.carry,     e.c);
    check({tag, "_overflow"},  bus.overflow,  e.v);
  endtask

  // poke: re-assert start with other operands while the op is in flight
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input vec_t exp,
                        input bit poke, input string tag);
    int lat;
    bit got;
    @(negedge clk);
    bus.a = a; bus.b = b; bus.start = 1'b1;
    sb.push_back(exp);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a = ~a; bus.b = 4'b0011;
    lat = 0; got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (poke && lat == 1) begin
        bus.start = 1'b1; bus.a = 4'b0101; bus.b = 4'b0000;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
      if (bus.done) got = 1'b1;
    end
    bus.start = 1'b0;
    check({tag, "_done_seen"}, got, 1);
    if (got) begin
      check({tag, "_latency"}, lat, exp_latency(a, b));
      check({tag, "_busy_at_done"}, bus.busy, 0);
      compare_result(tag);
      @(posedge clk);
      #1;
      check({tag, "_done_one_cycle"}, bus.done, 0);
    end else begin
      sb.delete();
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},      bus.busy,      0);
    check({tag, "_done"},      bus.done,      0);
    check({tag, "_quotient"},  bus.quotient,  0);
    check({tag, "_remainder"}, bus.remainder, 0);
    check({tag, "_flags"}, {bus.zero, bus.negative, bus.carry, bus.overflow}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t e;
    int   dones;
    logic [W-1:0] ra, rb;

    tbl[0]  = '{4'b0111, 4'b0010, 4'b0011, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{4'b1001, 4'b0010, 4'b1101, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{4'b0110, 4'b1101, 4'b1110, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{4'b1000, 4'b1111, 4'b1000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[4]  = '{4'b0101, 4'b0000, 4'b0000, 4'b0101, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{4'b0000, 4'b0011, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{4'b1000, 4'b0010, 4'b1100, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{4'b0111, 4'b1111, 4'b1001, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{4'b1111, 4'b1000, 4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{4'b1000, 4'b1000, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{4'b1000, 4'b0000, 4'b0000, 4'b1000, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{4'b0101, 4'b1110, 4'b1110, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0};

    bus.start = 1'b0; bus.a = '0; bus.b = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++)
      run_op(tbl[i].a, tbl[i].b, tbl[i], 1'b0, $sformatf("vec%0d", i));

    for (int i = 0; i < 16; i++) begin
      ra = W'($urandom_range(0, (1 << W) - 1));
      rb = W'($urandom_range(0, (1 << W) - 1));
      run_op(ra, rb, model(ra, rb), 1'b0, $sformatf("rnd%0d", i));
    end

    // start while busy must not disturb the op in flight
    run_op(4'b0111, 4'b0010, tbl[0], 1'b1, "busy_start");

    // start, ignored start at k+2, rst at k+3: abort with outputs cleared
    @(negedge clk);
    bus.a = 4'b1001; bus.b = 4'b0010; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.a = 4'b0110; bus.b = 4'b0001; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; rst = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("abort_rst");
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) dones++;
    end
    check("abort_no_done", dones, 0);
    run_op(4'b0110, 4'b1101, tbl[2], 1'b0, "after_abort");

    // rst and start together: reset wins
    @(negedge clk);
    rst = 1'b1; bus.start = 1'b1; bus.a = 4'b0111; bus.b = 4'b0010;
    @(posedge clk);
    #1;
    check("rst_start_busy", bus.busy, 0);
    check("rst_start_quotient", bus.quotient, 0);
    @(negedge clk);
    rst = 1'b0; bus.start = 1'b0;
    @(posedge clk);
    #1;
    check("rst_start_idle", bus.busy, 0);

    e = model(4'b1011, 4'b0011);
    run_op(4'b1011, 4'b0011, e, 1'b0, "final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
